hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL take parameters: SB_CNT_W, default 2, width of each per-register pending-write counter; PERF_W, default 32, width of the performance counters.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port de_valid, input, 1, DE holds a valid decoded instruction.
REQ-005 SHALL have ports de_rs1 and de_rs2, input, 5 each, source register numbers.
REQ-006 SHALL have ports de_use_rs1 and de_use_rs2, input, 1 each, instruction reads that source.
REQ-007 SHALL have ports de_wr_reg (input, 1) and de_rd (input, 5), the instruction writes rd.
REQ-008 SHALL have port de_is_branch, input, 1, instruction is a branch, JAL or JALR.
REQ-009 SHALL have ports agex_br_resolve and agex_br_taken, input, 1 each, AGEX resolves a branch this cycle and gives its outcome.
REQ-010 SHALL have ports wb_valid, wb_wr_reg (input, 1 each) and wb_rd (input, 5), WB retires a register write.
REQ-011 SHALL have ports stall_de and stall_fe, output, 1 each, hold the DE latch and hold the FE PC.
REQ-012 SHALL have ports issue, flush_de and redirect_fe, output, 1 each: DE advances to AGEX; DE latch becomes a bubble; FE takes the AGEX target.
REQ-013 SHALL have ports stall_cycles and flush_count, output, PERF_W each, performance counters.

Function
REQ-014 SHALL keep a scoreboard of 31 SB_CNT_W-bit counters for x1..x31; x0 SHALL always read as not busy and SHALL never be counted.
REQ-015 SHALL set src_busy when de_use_rsN is high, rsN is not 0, and the registered count for rsN is not 0. A WB decrement in the same cycle SHALL NOT clear busy; the register is free from the next cycle.
REQ-016 SHALL set sat_hazard when de_wr_reg is high, de_rd is not 0, and count[de_rd] equals 2^SB_CNT_W-1, so counters never overflow.
REQ-017 SHALL drive stall_de = de_valid & (src_busy | sat_hazard | state is not RUN), and issue = de_valid & ~stall_de. Both SHALL be combinational from registered state and current inputs.
REQ-018 SHALL update the scoreboard at the clock edge: +1 on issue & de_wr_reg & de_rd not 0; -1 on wb_valid & wb_wr_reg & wb_rd not 0. An increment and decrement on the same register in the same cycle SHALL leave it unchanged.
REQ-019 SHALL ignore (not decrement) a WB retire to a register whose count is 0.
REQ-020 SHALL implement an FSM with states RUN, BR_WAIT and FLUSH.
REQ-021 RUN SHALL go to BR_WAIT on issue & de_is_branch; otherwise it stays in RUN.
REQ-022 BR_WAIT SHALL assert stall_fe and block issue. On agex_br_resolve it goes to FLUSH if agex_br_taken is high, else to RUN; without resolve it stays in BR_WAIT.
REQ-023 FLUSH SHALL last exactly 1 cycle, asserting flush_de, redirect_fe and stall_fe, then return to RUN.
REQ-024 SHALL ignore agex_br_resolve in RUN or FLUSH: no state change, no outputs.
REQ-025 SHALL keep stall_fe low in RUN; FE back-pressure from stall_de is handled by DE.
REQ-026 SHALL not change the scoreboard when flush_de is asserted, because blocked instructions never incremented it.

Reset
REQ-027 On reset SHALL set state to RUN, clear all scoreboard counters and clear the performance counters.
REQ-028 While reset is high, SHALL drive stall_fe, flush_de and redirect_fe low, and SHALL drive issue and stall_de per REQ-017 with the cleared state.
REQ-029 Reset asserted in BR_WAIT or FLUSH SHALL abort the branch sequence with no redirect.

Configuration
REQ-030 With HAZARD_PERF_EN defined: stall_cycles SHALL increment on each cycle with stall_de high; flush_count SHALL increment on each cycle in FLUSH; both SHALL wrap modulo 2^PERF_W.
REQ-031 Without HAZARD_PERF_EN: stall_cycles and flush_count SHALL be constant 0, with no counter flops; ports remain present.

Verification
REQ-032 RAW: issue x5 write; next cycle DE uses rs1=5 -> stall_de=1 until WB retires x5, issue=1 the cycle after the retire.
REQ-033 x0: issue write to rd=0, then use rs1=0 -> no stall, scoreboard unchanged.
REQ-034 Saturation: 3 back-to-back writes to x7 with no WB; 4th write to x7 -> stall_de=1; one WB retire of x7 -> issue next cycle.
REQ-035 Same-cycle inc/dec: issue write x9 while WB retires x9 with count 1 -> count stays 1.
REQ-036 Taken branch: issue BEQ, resolve taken 1 cycle later -> BR_WAIT 1 cycle, FLUSH 1 cycle (flush_de=redirect_fe=1), RUN; flush_count=1 with HAZARD_PERF_EN.
REQ-037 Not-taken branch plus reset: resolve not-taken -> RUN with no flush. Assert reset in BR_WAIT -> RUN, stall_fe=0, all counters 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: DE decode info, AGEX branch
// resolution, WB retire info, and the stall/flush/redirect controls.
// master = pipeline side, slave = hazard controller side.
interface hazard_ctrl_if;
   logic       de_valid;
   logic [4:0] de_rs1;
   logic [4:0] de_rs2;
   logic       de_use_rs1;
   logic       de_use_rs2;
   logic       de_wr_reg;
   logic [4:0] de_rd;
   logic       de_is_branch;
   logic       agex_br_resolve;
   logic       agex_br_taken;
   logic       wb_valid;
   logic       wb_wr_reg;
   logic [4:0] wb_rd;
   logic       stall_de;
   logic       stall_fe;
   logic       issue;
   logic       flush_de;
   logic       redirect_fe;

   modport master (
      output de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2, de_wr_reg, de_rd,
             de_is_branch, agex_br_resolve, agex_br_taken, wb_valid, wb_wr_reg, wb_rd,
      input  stall_de, stall_fe, issue, flush_de, redirect_fe
   );

   modport slave (
      input  de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2, de_wr_reg, de_rd,
             de_is_branch, agex_br_resolve, agex_br_taken, wb_valid, wb_wr_reg, wb_rd,
      output stall_de, stall_fe, issue, flush_de, redirect_fe
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: per-register pending-write scoreboard for RAW and
// counter-saturation stalls, plus a RUN/BR_WAIT/FLUSH branch FSM.
// Optional feature macro: HAZARD_PERF_EN enables the stall/flush
// performance counters; without it both counters read as constant 0.
module hazard_ctrl #(
   parameter int SB_CNT_W = 2,
   parameter int PERF_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   hazard_ctrl_if.slave      bus,
   output logic [PERF_W-1:0] stall_cycles,
   output logic [PERF_W-1:0] flush_count
);

   typedef enum logic [1:0] {RUN = 2'd0, BR_WAIT = 2'd1, FLUSH = 2'd2} state_t;

   localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

   state_t              state, state_next, state_eff;
   logic [SB_CNT_W-1:0] sb_cnt [32];
   logic                rs1_busy, rs2_busy, src_busy, sat_hazard;
   logic                stall_int, issue_int;
   logic [31:0]         inc_vec, dec_vec;

   // Hazard detection from registered state; reset presents the cleared state.
   always_comb begin
      state_eff  = reset ? RUN : state;
      rs1_busy   = !reset && bus.de_use_rs1 && (bus.de_rs1 != 5'd0) && (sb_cnt[bus.de_rs1] != '0);
      rs2_busy   = !reset && bus.de_use_rs2 && (bus.de_rs2 != 5'd0) && (sb_cnt[bus.de_rs2] != '0);
      src_busy   = rs1_busy || rs2_busy;
      sat_hazard = !reset && bus.de_wr_reg && (bus.de_rd != 5'd0) && (sb_cnt[bus.de_rd] == CNT_MAX);
      stall_int  = bus.de_valid && (src_busy || sat_hazard || (state_eff != RUN));
      issue_int  = bus.de_valid && !stall_int;
   end

   assign bus.stall_de = stall_int;
   assign bus.issue    = issue_int;

   // Per-register increment (issued write) and decrement (retired write) requests.
   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      for (int i = 1; i < 32; i++) begin
         inc_vec[i] = issue_int && bus.de_wr_reg && (bus.de_rd == 5'(i));
         dec_vec[i] = bus.wb_valid && bus.wb_wr_reg && (bus.wb_rd == 5'(i)) && (sb_cnt[i] != '0);
      end
   end

   // Scoreboard counters; entry 0 is held at zero so x0 is never busy.
   // NOTE: the scoreboard is a bank of flops, not a RAM, so it is cleared on reset like any other state.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 32; i++) begin
         if (reset || (i == 0))
            sb_cnt[i] <= '0;
         else if (inc_vec[i] && !dec_vec[i])
            sb_cnt[i] <= sb_cnt[i] + SB_CNT_W'(1);
         else if (dec_vec[i] && !inc_vec[i])
            sb_cnt[i] <= sb_cnt[i] - SB_CNT_W'(1);
      end
   end

   // Branch FSM state register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= RUN;
      else       state <= state_next;
   end

   // Branch FSM next-state logic; resolve is only meaningful in BR_WAIT.
   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (issue_int && bus.de_is_branch) state_next = BR_WAIT;
         BR_WAIT: if (bus.agex_br_resolve) state_next = bus.agex_br_taken ? FLUSH : RUN;
         FLUSH:   state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // Branch FSM outputs; reset forces the RUN view so no redirect escapes.
   always_comb begin
      bus.stall_fe    = 1'b0;
      bus.flush_de    = 1'b0;
      bus.redirect_fe = 1'b0;
      case (state_eff)
         BR_WAIT: bus.stall_fe = 1'b1;
         FLUSH: begin
            bus.stall_fe    = 1'b1;
            bus.flush_de    = 1'b1;
            bus.redirect_fe = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef HAZARD_PERF_EN
   // Performance counters: DE stall cycles and FLUSH cycles, wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall_int)      stall_cycles <= stall_cycles + PERF_W'(1);
         if (state == FLUSH) flush_count  <= flush_count + PERF_W'(1);
      end
   end
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a table of per-cycle vectors with
// hand-computed expected outputs, plus hand-written reset-in-branch sequences.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] stall_cycles, flush_count;
   int          n_checks = 0;
   int          n_fail   = 0;

   hazard_ctrl_if hif ();

   hazard_ctrl #(.SB_CNT_W(2), .PERF_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (hif.slave),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic       wr;
      logic [4:0] rd;
      logic       br;
      logic       res;
      logic       tkn;
      logic       wbv;
      logic       wbw;
      logic [4:0] wbrd;
      logic       x_stall_de;
      logic       x_stall_fe;
      logic       x_issue;
      logic       x_flush;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(int v, int rs1, int u1, int rs2, int u2, int wr, int rd,
                               int br, int res, int tkn, int wbv, int wbw, int wbrd,
                               int xsd, int xsf, int xis, int xfl);
      vec_t r;
      r.v = 1'(v);     r.rs1 = 5'(rs1); r.u1 = 1'(u1); r.rs2 = 5'(rs2); r.u2 = 1'(u2);
      r.wr = 1'(wr);   r.rd = 5'(rd);   r.br = 1'(br); r.res = 1'(res); r.tkn = 1'(tkn);
      r.wbv = 1'(wbv); r.wbw = 1'(wbw); r.wbrd = 5'(wbrd);
      r.x_stall_de = 1'(xsd); r.x_stall_fe = 1'(xsf); r.x_issue = 1'(xis); r.x_flush = 1'(xfl);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t r);
      hif.de_valid        = r.v;
      hif.de_rs1          = r.rs1;
      hif.de_use_rs1      = r.u1;
      hif.de_rs2          = r.rs2;
      hif.de_use_rs2      = r.u2;
      hif.de_wr_reg       = r.wr;
      hif.de_rd           = r.rd;
      hif.de_is_branch    = r.br;
      hif.agex_br_resolve = r.res;
      hif.agex_br_taken   = r.tkn;
      hif.wb_valid        = r.wbv;
      hif.wb_wr_reg       = r.wbw;
      hif.wb_rd           = r.wbrd;
   endtask

   task automatic check_outs(input string tag, input logic sd, input logic sf,
                             input logic is, input logic fl);
      check({tag, " stall_de"},    32'(hif.stall_de),    32'(sd));
      check({tag, " stall_fe"},    32'(hif.stall_fe),    32'(sf));
      check({tag, " issue"},       32'(hif.issue),       32'(is));
      check({tag, " flush_de"},    32'(hif.flush_de),    32'(fl));
      check({tag, " redirect_fe"}, 32'(hif.redirect_fe), 32'(fl));
   endtask

   vec_t idle;
   vec_t r;
   int   exp_stalls;
   int   exp_flushes;

   initial begin
      idle = mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0);

      // RAW on x5 (WB with wr_reg low must not retire it)
      vecs.push_back(mk(1,0,0,0,0,1,5, 0,0,0, 0,0,0,  0,0,1,0));
      vecs.push_back(mk(1,5,1,0,0,0,0, 0,0,0, 0,0,0,  1,0,0,0));
      vecs.push_back(mk(1,5,1,0,0,0,0, 0,0,0, 1,0,5,  1,0,0,0));
      vecs.push_back(mk(1,5,1,0,0,0,0, 0,0,0, 1,1,5,  1,0,0,0));
      vecs.push_back(mk(1,5,1,0,0,0,0, 0,0,0, 0,0,0,  0,0,1,0));
      // x0 never counted, never busy
      vecs.push_back(mk(1,0,0,0,0,1,0, 0,0,0, 0,0,0,  0,0,1,0));
      vecs.push_back(mk(1,0,1,0,1,0,0, 0,0,0, 0,0,0,  0,0,1,0));
      // saturation on x7
      vecs.push_back(mk(1,0,0,0,0,1,7, 0,0,0, 0,0,0,  0,0,1,0));
      vecs.push_back(mk(1,0,0,0,0,1,7, 0,0,0, 0,0,0,  0,0,1,0));
      vecs.push_back(mk(1,0,0,0,0,1,7, 0,0,0, 0,0,0,  0,0,1,0));
      vecs.push_back(mk(1,0,0,0,0,1,7, 0,0,0, 0,0,0,  1,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,1,7, 0,0,0, 1,1,7,  1,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,1,7, 0,0,0, 0,0,0,  0,0,1,0));
      // rs2 hazard, then drain x7
      vecs.push_back(mk(1,5,1,7,1,0,0, 0,0,0, 0,0,0,  1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 1,1,7,  0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 1,1,7,  0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 1,1,7,  0,0,0,0));
      // retire to an idle register is ignored
      vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 1,1,12, 0,0,0,0));
      vecs.push_back(mk(1,12,1,0,0,0,0,0,0,0, 0,0,0,  0,0,1,0));
      // same-cycle inc/dec on x9 leaves count at 1
      vecs.push_back(mk(1,0,0,0,0,1,9, 0,0,0, 0,0,0,  0,0,1,0));
      vecs.push_back(mk(1,0,0,0,0,1,9, 0,0,0, 1,1,9,  0,0,1,0));
      vecs.push_back(mk(1,9,1,0,0,0,0, 0,0,0, 0,0,0,  1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 1,1,9,  0,0,0,0));
      vecs.push_back(mk(1,9,1,0,0,0,0, 0,0,0, 0,0,0,  0,0,1,0));
      // taken branch; resolves in FLUSH and RUN are ignored
      vecs.push_back(mk(1,0,0,0,0,0,0, 1,0,0, 0,0,0,  0,0,1,0));
      vecs.push_back(mk(1,0,0,0,0,0,0, 0,1,1, 0,0,0,  1,1,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0, 0,1,1, 0,0,0,  1,1,0,1));
      vecs.push_back(mk(1,0,0,0,0,0,0, 0,1,1, 0,0,0,  0,0,1,0));
      vecs.push_back(mk(1,0,0,0,0,0,0, 0,0,0, 0,0,0,  0,0,1,0));
      // not-taken branch
      vecs.push_back(mk(1,0,0,0,0,0,0, 1,0,0, 0,0,0,  0,0,1,0));
      vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0,  0,1,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0, 0,1,0, 0,0,0,  0,1,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0, 0,0,0, 0,0,0,  0,0,1,0));

      // reset: outputs follow the cleared state
      reset = 1'b1;
      drive(idle);
      @(negedge clk);
      #1 check_outs("reset idle", 0, 0, 0, 0);
      r = idle; r.v = 1'b1; r.rs1 = 5'd5; r.u1 = 1'b1;
      drive(r);
      #1 check_outs("reset valid", 0, 0, 1, 0);
      @(negedge clk);
      reset = 1'b0;
      drive(idle);
      #1;
      check("post-reset stall_cycles", stall_cycles, 32'd0);
      check("post-reset flush_count",  flush_count,  32'd0);

      exp_stalls  = 0;
      exp_flushes = 0;
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1 check_outs($sformatf("row%0d", i), vecs[i].x_stall_de, vecs[i].x_stall_fe,
                       vecs[i].x_issue, vecs[i].x_flush);
         if (vecs[i].x_stall_de) exp_stalls++;
         if (vecs[i].x_flush)    exp_flushes++;
      end
      @(negedge clk);
      drive(idle);
      #1;
`ifdef HAZARD_PERF_EN
      check("table stall_cycles", stall_cycles, 32'(exp_stalls));
      check("table flush_count",  flush_count,  32'(exp_flushes));
`else
      check("table stall_cycles", stall_cycles, 32'd0);
      check("table flush_count",  flush_count,  32'd0);
`endif

      // reset while in BR_WAIT with x3 pending: aborts branch, clears scoreboard
      r = idle; r.v = 1'b1; r.wr = 1'b1; r.rd = 5'd3;
      drive(r);
      @(negedge clk);
      r = idle; r.v = 1'b1; r.br = 1'b1;
      drive(r);
      @(negedge clk);
      drive(idle);
      #1 check("brwait stall_fe", 32'(hif.stall_fe), 32'd1);
      reset = 1'b1;
      r = idle; r.v = 1'b1; r.rs1 = 5'd3; r.u1 = 1'b1;
      drive(r);
      #1 check_outs("reset in brwait", 0, 0, 1, 0);
      @(negedge clk);
      reset = 1'b0;
      #1 check_outs("after brwait reset", 0, 0, 1, 0);
      check("brwait reset stall_cycles", stall_cycles, 32'd0);
      check("brwait reset flush_count",  flush_count,  32'd0);

      // reset while in FLUSH: no redirect, back to RUN
      @(negedge clk);
      r = idle; r.v = 1'b1; r.br = 1'b1;
      drive(r);
      @(negedge clk);
      r = idle; r.res = 1'b1; r.tkn = 1'b1;
      drive(r);
      #1 check("pre-flush stall_fe", 32'(hif.stall_fe), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      drive(idle);
      #1 check_outs("reset in flush", 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      r = idle; r.v = 1'b1;
      drive(r);
      #1 check_outs("after flush reset", 0, 0, 1, 0);
      check("flush reset flush_count", flush_count, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
